// File: rtl/operand_fetch_pkg.sv
// Shared uop, writeback and branch types for the operand fetch stage.
// EX_UOp is the execute-bound uop: R_UOp control fields plus resolved operands.
package operand_fetch_pkg;

  localparam int TAG_W = 7;
  localparam int SQN_W = 7;

  typedef logic [TAG_W-1:0] Tag;
  typedef logic [SQN_W-1:0] SqN;

  typedef enum logic [2:0] {
    FU_INT    = 3'd0,
    FU_LSU    = 3'd1,
    FU_MUL    = 3'd2,
    FU_DIV    = 3'd3,
    FU_BRANCH = 3'd4
  } FU_t;

  typedef struct packed {
    logic [31:0] imm;
    Tag          tagA;
    Tag          tagB;
    Tag          tagDst;
    logic [4:0]  nmDst;
    logic [5:0]  opcode;
    logic [4:0]  fetchID;
    logic [2:0]  fetchOffs;
    SqN          sqN;
    SqN          storeSqN;
    SqN          loadSqN;
    FU_t         fu;
    logic        compressed;
  } R_UOp;

  typedef struct packed {
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic [31:0] imm;
    SqN          sqN;
    Tag          tagDst;
    logic [4:0]  nmDst;
    logic [5:0]  opcode;
    logic [4:0]  fetchID;
    logic [2:0]  fetchOffs;
    SqN          storeSqN;
    SqN          loadSqN;
    FU_t         fu;
    logic        compressed;
  } EX_UOp;

  typedef struct packed {
    Tag          tagDst;
    logic [31:0] result;
  } RES_UOp;

  typedef struct packed {
    logic taken;
    SqN   sqN;
  } BranchProv;

  // Wrap-safe age compare: a is strictly younger than b.
  function automatic logic is_younger(input SqN a, input SqN b);
    SqN d;
    d = a - b;
    return $signed(d) > 0;
  endfunction

endpackage

// File: rtl/operand_fetch_bypass.sv
// Per-operand source select: immediate-zero tag, live result bus,
// entry-cycle bypass capture, then register file data.
module operand_bypass
  import operand_fetch_pkg::*;
#(
  parameter int RESULT_BUS_COUNT = 4
) (
  input  Tag          i_tag,
  input  logic        i_resultValid[RESULT_BUS_COUNT],
  input  RES_UOp      i_resultUOp[RESULT_BUS_COUNT],
  input  logic        i_bypValid,
  input  logic [31:0] i_bypData,
  input  logic [31:0] i_rfData,
  output logic [31:0] o_data
);

  // Descending scan so the lowest-index matching bus is the last writer.
  always_comb begin
    o_data = i_bypValid ? i_bypData : i_rfData;
    for (int i = RESULT_BUS_COUNT - 1; i >= 0; i--) begin
      if (i_resultValid[i] && (i_resultUOp[i].tagDst == i_tag))
        o_data = i_resultUOp[i].result;
    end
    if (i_tag[TAG_W-1])
      o_data = '0;
  end

endmodule

// File: rtl/operand_fetch.sv
// Two-stage operand fetch: S1 holds the uop while the RF read is in flight,
// S2 is the output register toward execute. Handles bypass, stall and flush.
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int RESULT_BUS_COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_stall,
  output logic        OUT_stall,
  input  logic        IN_uopValid,
  input  R_UOp        IN_uop,
  input  logic        IN_resultValid[RESULT_BUS_COUNT],
  input  RES_UOp      IN_resultUOp[RESULT_BUS_COUNT],
  input  BranchProv   IN_branch,
  output logic [5:0]  OUT_rfReadAddr[2],
  input  logic [31:0] IN_rfReadData[2],
  output logic        OUT_valid,
  output EX_UOp       OUT_uop
);

  logic             r_s1Valid;
  R_UOp             r_s1Uop;
  logic [1:0]       r_bypValid;
  logic [1:0][31:0] r_bypData;
  logic             r_s2Valid;
  EX_UOp            r_s2Uop;

  logic             w_s2Adv;
  logic             w_s1Adv;
  logic             w_accept;
  logic             w_killS1;
  logic             w_killS2;
  logic             w_killIn;
  Tag               w_inTag[2];
  Tag               w_s1Tag[2];
  logic [1:0]       w_capValid;
  logic [1:0][31:0] w_capData;
  logic [31:0]      w_src[2];
  EX_UOp            w_s2Next;

  assign w_inTag[0] = IN_uop.tagA;
  assign w_inTag[1] = IN_uop.tagB;
  assign w_s1Tag[0] = r_s1Uop.tagA;
  assign w_s1Tag[1] = r_s1Uop.tagB;

  assign w_killS1 = IN_branch.taken && is_younger(r_s1Uop.sqN, IN_branch.sqN);
  assign w_killS2 = IN_branch.taken && is_younger(r_s2Uop.sqN, IN_branch.sqN);
  assign w_killIn = IN_branch.taken && is_younger(IN_uop.sqN, IN_branch.sqN);

  assign w_s2Adv   = !r_s2Valid || !IN_stall;
  assign w_s1Adv   = w_s2Adv || !r_s1Valid;
  assign OUT_stall = r_s1Valid && !w_s2Adv;
  assign w_accept  = IN_uopValid && !OUT_stall && !w_killIn;

  // A bus write in the entry cycle races the RF read, so catch it here.
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      w_capValid[j] = 1'b0;
      w_capData[j]  = '0;
      for (int i = RESULT_BUS_COUNT - 1; i >= 0; i--) begin
        if (IN_resultValid[i] && (IN_resultUOp[i].tagDst == w_inTag[j])) begin
          w_capValid[j] = 1'b1;
          w_capData[j]  = IN_resultUOp[i].result;
        end
      end
    end
  end

  for (genvar j = 0; j < 2; j++) begin : g_opnd
    // Held S1 re-issues its own tags so the RF data stays current.
    assign OUT_rfReadAddr[j] = w_s1Adv ? w_inTag[j][5:0] : w_s1Tag[j][5:0];

    operand_bypass #(
      .RESULT_BUS_COUNT (RESULT_BUS_COUNT)
    ) u_byp (
      .i_tag         (w_s1Tag[j]),
      .i_resultValid (IN_resultValid),
      .i_resultUOp   (IN_resultUOp),
      .i_bypValid    (r_bypValid[j]),
      .i_bypData     (r_bypData[j]),
      .i_rfData      (IN_rfReadData[j]),
      .o_data        (w_src[j])
    );
  end

  always_comb begin
    w_s2Next            = '0;
    w_s2Next.srcA       = w_src[0];
    w_s2Next.srcB       = w_src[1];
    w_s2Next.imm        = r_s1Uop.imm;
    w_s2Next.sqN        = r_s1Uop.sqN;
    w_s2Next.tagDst     = r_s1Uop.tagDst;
    w_s2Next.nmDst      = r_s1Uop.nmDst;
    w_s2Next.opcode     = r_s1Uop.opcode;
    w_s2Next.fetchID    = r_s1Uop.fetchID;
    w_s2Next.fetchOffs  = r_s1Uop.fetchOffs;
    w_s2Next.storeSqN   = r_s1Uop.storeSqN;
    w_s2Next.loadSqN    = r_s1Uop.loadSqN;
    w_s2Next.fu         = r_s1Uop.fu;
    w_s2Next.compressed = r_s1Uop.compressed;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1Valid  <= 1'b0;
      r_s1Uop    <= '0;
      r_bypValid <= '0;
      r_bypData  <= '0;
      r_s2Valid  <= 1'b0;
      r_s2Uop    <= '0;
    end else begin
      if (w_s2Adv) begin
        r_s2Valid <= r_s1Valid && !w_killS1;
        if (r_s1Valid)
          r_s2Uop <= w_s2Next;
      end else begin
        r_s2Valid <= r_s2Valid && !w_killS2;
      end

      if (w_s1Adv) begin
        r_s1Valid <= w_accept;
        if (w_accept) begin
          r_s1Uop    <= IN_uop;
          r_bypValid <= w_capValid;
          r_bypData  <= w_capData;
        end
      end else begin
        r_s1Valid <= r_s1Valid && !w_killS1;
      end
    end
  end

  assign OUT_valid = r_s2Valid;
  assign OUT_uop   = r_s2Uop;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: table of single-uop bypass vectors plus
// hand sequences for stall, branch flush and mid-operation reset.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        IN_stall;
  logic        OUT_stall;
  logic        IN_uopValid;
  R_UOp        IN_uop;
  logic        rv[NB];
  RES_UOp      ru[NB];
  BranchProv   br;
  logic [5:0]  ra[2];
  logic [31:0] rd[2];
  logic        OUT_valid;
  EX_UOp       OUT_uop;

  logic [31:0] rf[64];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Registered RF read: data arrives one cycle after the address.
  always @(posedge clk) begin
    rd[0] <= rf[ra[0]];
    rd[1] <= rf[ra[1]];
  end

  operand_fetch #(.RESULT_BUS_COUNT(NB)) dut (
    .clk            (clk),
    .rst            (rst),
    .IN_stall       (IN_stall),
    .OUT_stall      (OUT_stall),
    .IN_uopValid    (IN_uopValid),
    .IN_uop         (IN_uop),
    .IN_resultValid (rv),
    .IN_resultUOp   (ru),
    .IN_branch      (br),
    .OUT_rfReadAddr (ra),
    .IN_rfReadData  (rd),
    .OUT_valid      (OUT_valid),
    .OUT_uop        (OUT_uop)
  );

  typedef struct {
    Tag          tagA;
    Tag          tagB;
    logic [31:0] rfA;
    logic [31:0] rfB;
    logic        eV;
    int          eBus;
    Tag          eTag;
    logic [31:0] eRes;
    logic        s0V;
    Tag          s0Tag;
    logic [31:0] s0Res;
    logic        s1V;
    Tag          s1Tag;
    logic [31:0] s1Res;
    logic [31:0] expA;
    logic [31:0] expB;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_bus();
    for (int i = 0; i < NB; i++) begin
      rv[i] = 1'b0;
      ru[i] = '0;
    end
  endtask

  function automatic R_UOp mk(input Tag a, input Tag b, input SqN s, input logic [31:0] imm);
    R_UOp u;
    u        = '0;
    u.tagA   = a;
    u.tagB   = b;
    u.sqN    = s;
    u.imm    = imm;
    u.tagDst = 7'h30;
    u.opcode = 6'h15;
    u.fu     = FU_INT;
    return u;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) rf[i] = '0;
    rst = 1'b0; IN_stall = 1'b0; IN_uopValid = 1'b0; IN_uop = '0; br = '0;
    clr_bus();

    //          tagA   tagB   rfA     rfB     eV  eBus eTag   eRes         s0V s0Tag  s0Res        s1V s1Tag  s1Res        expA         expB
    vecs[0] = '{7'h05, 7'h07, 32'h11, 32'h22, 0, 0, 7'h00, 32'h0,        0, 7'h00, 32'h0,        0, 7'h00, 32'h0,        32'h11,      32'h22};
    vecs[1] = '{7'h05, 7'h07, 32'h00, 32'h22, 1, 0, 7'h05, 32'hAB,       0, 7'h00, 32'h0,        0, 7'h00, 32'h0,        32'hAB,      32'h22};
    vecs[2] = '{7'h03, 7'h40, 32'h33, 32'h99, 0, 0, 7'h00, 32'h0,        1, 7'h40, 32'h55,       1, 7'h40, 32'h66,       32'h33,      32'h0};
    vecs[3] = '{7'h09, 7'h09, 32'h44, 32'h44, 0, 0, 7'h00, 32'h0,        1, 7'h09, 32'h77,       0, 7'h00, 32'h0,        32'h77,      32'h77};
    vecs[4] = '{7'h0A, 7'h0B, 32'h1A, 32'h1B, 0, 0, 7'h00, 32'h0,        1, 7'h0A, 32'hA0,       1, 7'h0A, 32'hB0,       32'hA0,      32'h1B};
    vecs[5] = '{7'h14, 7'h15, 32'h200, 32'h210, 1, 3, 7'h15, 32'hCAFE,   1, 7'h14, 32'hBEEF,     0, 7'h00, 32'h0,        32'hBEEF,    32'hCAFE};
    vecs[6] = '{7'h16, 7'h17, 32'h220, 32'h230, 1, 2, 7'h16, 32'h1,      0, 7'h00, 32'h0,        1, 7'h16, 32'h2,        32'h2,       32'h230};
    vecs[7] = '{7'h40, 7'h18, 32'h5,  32'h240, 1, 1, 7'h40, 32'h77,      0, 7'h00, 32'h0,        0, 7'h00, 32'h0,        32'h0,       32'h240};

    #12;
    chk("reset OUT_valid", 32'(OUT_valid), 32'd0);
    chk("reset OUT_stall", 32'(OUT_stall), 32'd0);
    chk("reset OUT_uop.imm", OUT_uop.imm, 32'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      rf[vecs[i].tagA[5:0]] = vecs[i].rfA;
      rf[vecs[i].tagB[5:0]] = vecs[i].rfB;
      clr_bus();
      IN_uop      = mk(vecs[i].tagA, vecs[i].tagB, SqN'(i + 1), 32'h1000 + i);
      IN_uopValid = 1'b1;
      if (vecs[i].eV) begin
        rv[vecs[i].eBus] = 1'b1;
        ru[vecs[i].eBus] = '{vecs[i].eTag, vecs[i].eRes};
      end
      #1;
      chk($sformatf("v%0d rfAddrA", i), 32'(ra[0]), 32'(vecs[i].tagA[5:0]));
      chk($sformatf("v%0d rfAddrB", i), 32'(ra[1]), 32'(vecs[i].tagB[5:0]));
      chk($sformatf("v%0d OUT_stall", i), 32'(OUT_stall), 32'd0);
      tick();
      IN_uopValid = 1'b0;
      clr_bus();
      rv[0] = vecs[i].s0V; ru[0] = '{vecs[i].s0Tag, vecs[i].s0Res};
      rv[1] = vecs[i].s1V; ru[1] = '{vecs[i].s1Tag, vecs[i].s1Res};
      chk($sformatf("v%0d valid@1", i), 32'(OUT_valid), 32'd0);
      tick();
      clr_bus();
      chk($sformatf("v%0d valid@2", i), 32'(OUT_valid), 32'd1);
      chk($sformatf("v%0d srcA", i), OUT_uop.srcA, vecs[i].expA);
      chk($sformatf("v%0d srcB", i), OUT_uop.srcB, vecs[i].expB);
      chk($sformatf("v%0d imm", i), OUT_uop.imm, 32'h1000 + i);
      chk($sformatf("v%0d opcode", i), 32'(OUT_uop.opcode), 32'h15);
      tick();
    end
    chk("drain valid", 32'(OUT_valid), 32'd0);

    // Stall with both stages full; S1 must keep re-reading its tags.
    for (int i = 1; i <= 6; i++) rf[i] = 32'h100 + i;
    IN_uop = mk(7'd1, 7'd2, 7'd30, 32'hA1); IN_uopValid = 1'b1;
    tick();
    IN_uop = mk(7'd3, 7'd4, 7'd31, 32'hA2);
    tick();
    chk("stall pre sqN", 32'(OUT_uop.sqN), 32'd30);
    chk("stall pre srcA", OUT_uop.srcA, 32'h101);
    IN_stall = 1'b1;
    IN_uop   = mk(7'd5, 7'd6, 7'd32, 32'hA3);
    rf[3]    = 32'h333;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d OUT_stall", k), 32'(OUT_stall), 32'd1);
      chk($sformatf("stall%0d rfAddrA", k), 32'(ra[0]), 32'd3);
      chk($sformatf("stall%0d rfAddrB", k), 32'(ra[1]), 32'd4);
      chk($sformatf("stall%0d OUT_valid", k), 32'(OUT_valid), 32'd1);
      chk($sformatf("stall%0d sqN", k), 32'(OUT_uop.sqN), 32'd30);
      chk($sformatf("stall%0d srcB", k), OUT_uop.srcB, 32'h102);
      tick();
    end
    IN_stall = 1'b0;
    #1;
    chk("release OUT_stall", 32'(OUT_stall), 32'd0);
    chk("release rfAddrA", 32'(ra[0]), 32'd5);
    tick();
    IN_uopValid = 1'b0;
    chk("release U2 sqN", 32'(OUT_uop.sqN), 32'd31);
    chk("release U2 srcA reread", OUT_uop.srcA, 32'h333);
    chk("release U2 srcB", OUT_uop.srcB, 32'h104);
    tick();
    chk("release U3 valid", 32'(OUT_valid), 32'd1);
    chk("release U3 sqN", 32'(OUT_uop.sqN), 32'd32);
    chk("release U3 srcA", OUT_uop.srcA, 32'h105);
    tick();
    chk("release drain", 32'(OUT_valid), 32'd0);

    // Branch at sqN 11 kills S1 (12) but not the stalled S2 (10).
    IN_uop = mk(7'd1, 7'd2, 7'd10, 32'hB0); IN_uopValid = 1'b1;
    tick();
    IN_uop = mk(7'd3, 7'd4, 7'd12, 32'hB2);
    tick();
    IN_uop   = mk(7'd5, 7'd6, 7'd13, 32'hB3);
    IN_stall = 1'b1;
    br       = '{1'b1, 7'd11};
    tick();
    br = '0; IN_stall = 1'b0; IN_uopValid = 1'b0;
    chk("flush S2 valid", 32'(OUT_valid), 32'd1);
    chk("flush S2 sqN", 32'(OUT_uop.sqN), 32'd10);
    tick();
    chk("flush S1 gone", 32'(OUT_valid), 32'd0);
    tick();
    chk("flush nothing late", 32'(OUT_valid), 32'd0);

    // Incoming uop younger than the branch is refused; an equal one is kept.
    IN_uop = mk(7'd7, 7'd8, 7'd20, 32'hC0); IN_uopValid = 1'b1;
    br = '{1'b1, 7'd19};
    tick();
    IN_uopValid = 1'b0; br = '0;
    tick();
    chk("flush in younger", 32'(OUT_valid), 32'd0);
    IN_uop = mk(7'd7, 7'd8, 7'd19, 32'hC1); IN_uopValid = 1'b1;
    br = '{1'b1, 7'd19};
    tick();
    IN_uopValid = 1'b0; br = '0;
    tick();
    chk("flush in equal valid", 32'(OUT_valid), 32'd1);
    chk("flush in equal imm", OUT_uop.imm, 32'hC1);
    tick();
    chk("flush in equal once", 32'(OUT_valid), 32'd0);

    // Reset with both stages full and the output stalled.
    IN_uop = mk(7'd1, 7'd2, 7'd40, 32'hD0); IN_uopValid = 1'b1;
    tick();
    IN_uop = mk(7'd3, 7'd4, 7'd41, 32'hD1);
    tick();
    IN_stall = 1'b1; IN_uopValid = 1'b0;
    tick();
    chk("pre-reset valid", 32'(OUT_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("reset async valid", 32'(OUT_valid), 32'd0);
    chk("reset async stall", 32'(OUT_stall), 32'd0);
    chk("reset async imm", OUT_uop.imm, 32'd0);
    tick();
    #2;
    rst = 1'b1; IN_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post-reset%0d valid", k), 32'(OUT_valid), 32'd0);
    end
    IN_uop = mk(7'd1, 7'd2, 7'd50, 32'hE0); IN_uopValid = 1'b1;
    tick();
    IN_uopValid = 1'b0;
    tick();
    chk("post-reset accept valid", 32'(OUT_valid), 32'd1);
    chk("post-reset accept imm", OUT_uop.imm, 32'hE0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
